// File: rtl/code_lock_ctrl.sv
// Sequential back end of the 1-4-6-9 keypad lock: holds the sequence state fed
// back to the decoder, drives the timed unlock, and enforces a failure lockout.
module code_lock_ctrl #(
    parameter int UNLOCK_CYCLES  = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_valid_i,
    input  logic [2:0] NextState_i,
    output logic [2:0] CurrentState_o,
    output logic       unlock_o,
    output logic       locked_out_o,
    output logic [1:0] fail_cnt_o,
    output logic       key_drop_o
);

    typedef enum logic [1:0] {
        TRACK,
        OPEN,
        LOCKOUT
    } mode_t;

    localparam logic [7:0] UNLOCK_LOAD  = 8'(UNLOCK_CYCLES - 1);
    localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] MAX_FAIL_W   = 3'(MAX_FAIL);

    mode_t      mode_q, mode_nxt;
    logic [2:0] state_q, state_nxt;
    logic       unlock_q, unlock_nxt;
    logic       locked_q, locked_nxt;
    logic [1:0] fail_q, fail_nxt;
    logic       drop_q, drop_nxt;
    logic [7:0] timer_q, timer_nxt;
    logic [2:0] fail_inc;

    // Widened so the comparison against MAX_FAIL cannot wrap at 2 bits.
    assign fail_inc = {1'b0, fail_q} + 3'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= TRACK;
            state_q  <= 3'd0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 2'd0;
            drop_q   <= 1'b0;
            timer_q  <= 8'd0;
        end else begin
            mode_q   <= mode_nxt;
            state_q  <= state_nxt;
            unlock_q <= unlock_nxt;
            locked_q <= locked_nxt;
            fail_q   <= fail_nxt;
            drop_q   <= drop_nxt;
            timer_q  <= timer_nxt;
        end
    end

    always_comb begin
        mode_nxt   = mode_q;
        state_nxt  = state_q;
        unlock_nxt = unlock_q;
        locked_nxt = locked_q;
        fail_nxt   = fail_q;
        drop_nxt   = 1'b0;
        timer_nxt  = timer_q;

        case (mode_q)
            TRACK: begin
                if (key_valid_i) begin
                    if (NextState_i == 3'd4) begin
                        state_nxt  = 3'd4;
                        fail_nxt   = 2'd0;
                        timer_nxt  = UNLOCK_LOAD;
                        unlock_nxt = 1'b1;
                        mode_nxt   = OPEN;
                    end else if (NextState_i >= 3'd1 && NextState_i <= 3'd3) begin
                        state_nxt = NextState_i;
                    end else begin
                        // Decoder values 0 and 5..7 all count as a wrong digit.
                        state_nxt = 3'd0;
                        if (fail_inc == MAX_FAIL_W) begin
                            fail_nxt   = MAX_FAIL_W[1:0];
                            timer_nxt  = LOCKOUT_LOAD;
                            locked_nxt = 1'b1;
                            mode_nxt   = LOCKOUT;
                        end else begin
                            fail_nxt = fail_inc[1:0];
                        end
                    end
                end
            end
            OPEN: begin
                drop_nxt = key_valid_i;
                if (timer_q == 8'd0) begin
                    unlock_nxt = 1'b0;
                    state_nxt  = 3'd0;
                    mode_nxt   = TRACK;
                end else begin
                    timer_nxt = timer_q - 8'd1;
                end
            end
            LOCKOUT: begin
                drop_nxt = key_valid_i;
                if (timer_q == 8'd0) begin
                    locked_nxt = 1'b0;
                    fail_nxt   = 2'd0;
                    mode_nxt   = TRACK;
                end else begin
                    timer_nxt = timer_q - 8'd1;
                end
            end
            default: begin
                mode_nxt = TRACK;
            end
        endcase
    end

    assign CurrentState_o = state_q;
    assign unlock_o       = unlock_q;
    assign locked_out_o   = locked_q;
    assign fail_cnt_o     = fail_q;
    assign key_drop_o     = drop_q;

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Sequential back end of the 1-4-6-9 keypad lock; sits directly downstream of the combinational next-state decoder.
- Holds the sequence state register and feeds it back to the decoder as the current state. Consumes the decoder's next state once per accepted key strobe.
- Generates a timed unlock output, counts failed entries, and enforces a timed lockout after repeated failures.

Parameters:
- UNLOCK_CYCLES, 8, cycles unlock_o stays high after a correct sequence (legal range 1..255).
- MAX_FAIL, 3, failed keys that trigger lockout (legal range 1..3).
- LOCKOUT_CYCLES, 16, cycles locked_out_o stays high (legal range 1..255).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- key_valid_i  in  1  single-cycle strobe: a new digit is present at the decoder input this cycle.
- NextState_i  in  3  next state from the decoder (S0=0 .. S4=4).
- CurrentState_o  out  3  registered sequence state, fed back to the decoder.
- unlock_o  out  1  high while the lock is open.
- locked_out_o  out  1  high during lockout.
- fail_cnt_o  out  2  current consecutive-failure count.
- key_drop_o  out  1  one-cycle pulse: a strobe arrived while in OPEN or LOCKOUT and was ignored.

Behaviour:
- Reset (rst_i=1 at an edge):
  - Mode=TRACK; CurrentState_o=0; unlock_o=0; locked_out_o=0; fail_cnt_o=0; key_drop_o=0; timer=0.
  - Reset overrides everything, including mid-OPEN and mid-LOCKOUT.
- All outputs are registered. A key strobe in cycle k affects outputs from cycle k+1.
- Mode FSM has three states: TRACK, OPEN, LOCKOUT.
- TRACK, key_valid_i=1 ("accepted key"), evaluated in this order:
  1. NextState_i==4: CurrentState_o<=4; fail_cnt<=0; timer<=UNLOCK_CYCLES-1; unlock_o<=1; go to OPEN.
  2. NextState_i in {1,2,3}: CurrentState_o<=NextState_i; fail_cnt unchanged.
  3. NextState_i==0 or 5..7 (out-of-range values are treated as 0): CurrentState_o<=0; this is a failure.
     - If fail_cnt+1==MAX_FAIL: fail_cnt<=MAX_FAIL; timer<=LOCKOUT_CYCLES-1; locked_out_o<=1; go to LOCKOUT.
     - Otherwise fail_cnt<=fail_cnt+1.
- TRACK, key_valid_i=0: everything holds. There is no inactivity timeout.
- OPEN:
  - unlock_o=1 for exactly UNLOCK_CYCLES cycles; timer decrements each cycle.
  - When timer==0: unlock_o<=0; CurrentState_o<=0; go to TRACK. The next cycle is TRACK and accepts keys.
- LOCKOUT:
  - locked_out_o=1 for exactly LOCKOUT_CYCLES cycles; CurrentState_o=0.
  - When timer==0: locked_out_o<=0; fail_cnt<=0; go to TRACK.
- Strobes in OPEN or LOCKOUT:
  - Ignored: no state, counter or timer change; key_drop_o<=1 for the next cycle.
  - A strobe on the exit cycle (timer==0) is also dropped.
- Invariants:
  - unlock_o and locked_out_o are never high together.
  - fail_cnt_o never exceeds MAX_FAIL.
- A restart digit (1 while in S1..S3, decoder returns 1) is not a failure and does not clear fail_cnt.

Test Plan:
- Reset then keys 1,4,6,9 one cycle apart -> CurrentState_o 1,2,3,4. unlock_o high for exactly 8 cycles starting the cycle after the 9 strobe. Then CurrentState_o=0, fail_cnt_o=0.
- Keys 1,4,7 (decoder gives 0) -> fail_cnt_o=1, CurrentState_o=0. Then 1,4,6,9 -> unlock_o asserts and fail_cnt_o=0.
- Three wrong keys (e.g. 5,5,5) -> fail_cnt_o 1,2,3. locked_out_o high 16 cycles from the cycle after the third strobe. Then fail_cnt_o=0 and TRACK.
- Strobe digit 1 during OPEN and during LOCKOUT -> key_drop_o one-cycle pulse each time; CurrentState_o, fail_cnt_o and remaining timer length unaffected.
- Force NextState_i=6 with key_valid_i=1 -> counted as a failure, CurrentState_o=0.
- Assert rst_i at OPEN cycle 3 and at LOCKOUT cycle 5 -> next cycle all outputs 0, mode TRACK. An immediate 1,4,6,9 unlocks normally.
